// File: rtl/cdc_req_tx_if.sv
// Local-side and receiver-side signals of the req/ack transmit block.
interface cdc_req_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;
  logic                  tx_done;
  logic                  tx_err;
  logic                  busy;
  logic                  req_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ack_async;

  // Transmit block view
  modport slave (
    input  tx_valid, tx_data, ack_async,
    output tx_ready, tx_done, tx_err, busy, req_out, data_out
  );

  // Local logic plus receiver view
  modport master (
    output tx_valid, tx_data, ack_async,
    input  tx_ready, tx_done, tx_err, busy, req_out, data_out
  );
endinterface

// File: rtl/cdc_req_tx.sv
// Transmit side of a four-phase req/ack CDC handshake with ack synchronizer
// and request timeout.
module cdc_req_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         n_rst,
  cdc_req_tx_if.slave  bus
);

  localparam int unsigned TMO_W = 16;
  // The abort edge lands TIMEOUT+1 edges after the acceptance edge.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    ABORT   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  ack_s1_q, ack_s1_d;
  logic                  ack_sync_q, ack_sync_d;
  logic                  tx_ready_c;

  // A stale synchronized ack blocks acceptance until the receiver has released.
  assign tx_ready_c   = (state_q == IDLE) && !ack_sync_q;
  assign bus.tx_ready = tx_ready_c;
  assign bus.busy     = (state_q != IDLE);
  assign bus.req_out  = req_q;
  assign bus.data_out = data_q;
  assign bus.tx_done  = done_q;
  assign bus.tx_err   = err_q;

  // Next-state, handshake outputs, timeout counter and ack synchronizer inputs.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tmo_d      = tmo_q;
    ack_s1_d   = bus.ack_async;
    ack_sync_d = ack_s1_q;

    case (state_q)
      IDLE: begin
        if (bus.tx_valid && tx_ready_c) begin
          data_d  = bus.tx_data;
          req_d   = 1'b1;
          tmo_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack has priority over a timeout reached on the same edge.
        if (ack_sync_q) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          req_d   = 1'b0;
          state_d = ABORT;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RELEASE: begin
        if (!ack_sync_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ABORT: begin
        // Wait out a late ack so it cannot be mistaken for the next transfer's.
        if (!ack_sync_q) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State, registered outputs and the two-flop ack synchronizer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      ack_s1_q   <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      ack_s1_q   <= ack_s1_d;
      ack_sync_q <= ack_sync_d;
    end
  end

endmodule

// File: tb/tb_cdc_req_tx.sv
// Directed bench for cdc_req_tx: two instances, long timeout (a) and TIMEOUT=4 (b).
module tb_cdc_req_tx;

  logic clk = 1'b0;
  logic n_rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cdc_req_tx_if #(.DATA_WIDTH(8)) bus_a ();
  cdc_req_tx_if #(.DATA_WIDTH(8)) bus_b ();

  cdc_req_tx #(.DATA_WIDTH(8), .TIMEOUT(20)) dut_a (.clk(clk), .n_rst(n_rst), .bus(bus_a));
  cdc_req_tx #(.DATA_WIDTH(8), .TIMEOUT(4))  dut_b (.clk(clk), .n_rst(n_rst), .bus(bus_b));

  // Status vector: {req_out, busy, tx_ready, tx_done, tx_err}
  logic [4:0] st_a, st_b;
  assign st_a = {bus_a.req_out, bus_a.busy, bus_a.tx_ready, bus_a.tx_done, bus_a.tx_err};
  assign st_b = {bus_b.req_out, bus_b.busy, bus_b.tx_ready, bus_b.tx_done, bus_b.tx_err};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    bus_a.tx_valid = 1'b0; bus_a.tx_data = 8'h00; bus_a.ack_async = 1'b0;
    bus_b.tx_valid = 1'b0; bus_b.tx_data = 8'h00; bus_b.ack_async = 1'b0;
    #2;
    checks++;
    if (st_a !== 5'b00100) begin
      errors++; $display("FAIL reset_status_a: got %b expected %b", st_a, 5'b00100);
    end
    checks++;
    if (st_b !== 5'b00100) begin
      errors++; $display("FAIL reset_status_b: got %b expected %b", st_b, 5'b00100);
    end
    checks++;
    if (bus_a.data_out !== 8'h00) begin
      errors++; $display("FAIL reset_data_a: got %h expected %h", bus_a.data_out, 8'h00);
    end
    #10 n_rst = 1'b1;
    tick;
    bus_a.tx_valid = 1'b1; bus_a.tx_data = 8'h5A;
    tick;
    bus_a.tx_valid = 1'b0;
    checks++;
    if (st_a !== 5'b11000 || bus_a.data_out !== 8'h5A) begin
      errors++; $display("FAIL reset_pre_accept: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b11000, 8'h5A);
    end
    // Mid-cycle asynchronous reset
    #3 n_rst = 1'b0;
    #1;
    checks++;
    if (st_a !== 5'b00100 || bus_a.data_out !== 8'h00) begin
      errors++; $display("FAIL reset_async: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b00100, 8'h00);
    end
    #2 n_rst = 1'b1;
    tick;
  endtask

  task automatic test_normal;
    int n;
    bus_a.tx_data = 8'hA5; bus_a.tx_valid = 1'b1;
    tick;
    bus_a.tx_valid = 1'b0; bus_a.tx_data = 8'h00;
    checks++;
    if (st_a !== 5'b11000 || bus_a.data_out !== 8'hA5) begin
      errors++; $display("FAIL normal_accept: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b11000, 8'hA5);
    end
    repeat (3) begin
      tick;
      checks++;
      if (st_a !== 5'b11000 || bus_a.data_out !== 8'hA5) begin
        errors++; $display("FAIL normal_req_hold: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b11000, 8'hA5);
      end
    end
    bus_a.ack_async = 1'b1;
    n = 0;
    while (bus_a.req_out === 1'b1 && n < 10) begin
      tick;
      n++;
      checks++;
      if (bus_a.data_out !== 8'hA5 || bus_a.tx_done !== 1'b0 || bus_a.tx_err !== 1'b0) begin
        errors++; $display("FAIL normal_wait_ack: got data %h done %b err %b expected a5 0 0", bus_a.data_out, bus_a.tx_done, bus_a.tx_err);
      end
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL normal_req_fall_latency: got %0d expected %0d", n, 3);
    end
    repeat (3) begin
      tick;
      checks++;
      if (st_a !== 5'b01000 || bus_a.data_out !== 8'hA5) begin
        errors++; $display("FAIL normal_release_hold: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b01000, 8'hA5);
      end
    end
    bus_a.ack_async = 1'b0;
    repeat (2) begin
      tick;
      checks++;
      if (st_a !== 5'b01000) begin
        errors++; $display("FAIL normal_ack_fall_sync: got %b expected %b", st_a, 5'b01000);
      end
    end
    tick;
    checks++;
    if (st_a !== 5'b00110 || bus_a.data_out !== 8'hA5) begin
      errors++; $display("FAIL normal_done: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b00110, 8'hA5);
    end
    tick;
    checks++;
    if (st_a !== 5'b00100) begin
      errors++; $display("FAIL normal_done_single: got %b expected %b", st_a, 5'b00100);
    end
  endtask

  task automatic test_back_to_back;
    logic       prev_req;
    logic [7:0] prev_data;
    int         done1, done2, acc2;
    bus_a.tx_data = 8'h01; bus_a.tx_valid = 1'b1;
    tick;
    checks++;
    if (st_a !== 5'b11000 || bus_a.data_out !== 8'h01) begin
      errors++; $display("FAIL b2b_accept1: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b11000, 8'h01);
    end
    bus_a.tx_data = 8'h02;
    prev_req = 1'b1; prev_data = 8'h01;
    done1 = 0; done2 = 0; acc2 = 0;
    for (int c = 1; c <= 14; c++) begin
      bus_a.ack_async = bus_a.req_out;
      tick;
      checks++;
      if (prev_req === 1'b1 && bus_a.data_out !== prev_data) begin
        errors++; $display("FAIL b2b_data_while_req: cycle %0d got %h expected %h", c, bus_a.data_out, prev_data);
      end
      if (bus_a.tx_done === 1'b1) begin
        if (done1 == 0) done1 = c; else done2 = c;
        checks++;
        if (bus_a.tx_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready_in_done: cycle %0d got %b expected 1", c, bus_a.tx_ready);
        end
      end
      if (acc2 == 0 && bus_a.data_out === 8'h02) begin
        acc2 = c;
        bus_a.tx_valid = 1'b0;
      end
      prev_req = bus_a.req_out; prev_data = bus_a.data_out;
    end
    checks++;
    if (done1 != 6 || acc2 != 7 || done2 != 13) begin
      errors++; $display("FAIL b2b_timing: got done1=%0d acc2=%0d done2=%0d expected 6 7 13", done1, acc2, done2);
    end
    checks++;
    if (st_a !== 5'b00100 || bus_a.data_out !== 8'h02) begin
      errors++; $display("FAIL b2b_final: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b00100, 8'h02);
    end
  endtask

  task automatic test_timeout;
    int n;
    bus_b.ack_async = 1'b0;
    bus_b.tx_data = 8'h3C; bus_b.tx_valid = 1'b1;
    tick;
    bus_b.tx_valid = 1'b0;
    checks++;
    if (st_b !== 5'b11000 || bus_b.data_out !== 8'h3C) begin
      errors++; $display("FAIL tmo_accept: got %b/%h expected %b/%h", st_b, bus_b.data_out, 5'b11000, 8'h3C);
    end
    n = 0;
    while (bus_b.req_out === 1'b1 && n < 20) begin
      n++;
      tick;
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL tmo_req_cycles: got %0d expected %0d", n, 5);
    end
    checks++;
    if (st_b !== 5'b01000) begin
      errors++; $display("FAIL tmo_abort_state: got %b expected %b", st_b, 5'b01000);
    end
    tick;
    checks++;
    if (st_b !== 5'b00101 || bus_b.data_out !== 8'h3C) begin
      errors++; $display("FAIL tmo_err_pulse: got %b/%h expected %b/%h", st_b, bus_b.data_out, 5'b00101, 8'h3C);
    end
    tick;
    checks++;
    if (st_b !== 5'b00100) begin
      errors++; $display("FAIL tmo_err_single: got %b expected %b", st_b, 5'b00100);
    end
  endtask

  task automatic test_late_ack;
    bus_b.tx_data = 8'h7E; bus_b.tx_valid = 1'b1;
    tick;
    bus_b.tx_valid = 1'b0;
    repeat (3) tick;
    bus_b.ack_async = 1'b1;
    tick;
    checks++;
    if (st_b !== 5'b11000) begin
      errors++; $display("FAIL late_still_req: got %b expected %b", st_b, 5'b11000);
    end
    tick;
    checks++;
    if (st_b !== 5'b01000) begin
      errors++; $display("FAIL late_abort_entry: got %b expected %b", st_b, 5'b01000);
    end
    repeat (3) begin
      tick;
      checks++;
      if (st_b !== 5'b01000) begin
        errors++; $display("FAIL late_abort_hold: got %b expected %b", st_b, 5'b01000);
      end
    end
    bus_b.ack_async = 1'b0;
    repeat (2) begin
      tick;
      checks++;
      if (st_b !== 5'b01000) begin
        errors++; $display("FAIL late_ack_fall_sync: got %b expected %b", st_b, 5'b01000);
      end
    end
    tick;
    checks++;
    if (st_b !== 5'b00101 || bus_b.data_out !== 8'h7E) begin
      errors++; $display("FAIL late_err_pulse: got %b/%h expected %b/%h", st_b, bus_b.data_out, 5'b00101, 8'h7E);
    end
    tick;
    checks++;
    if (st_b !== 5'b00100) begin
      errors++; $display("FAIL late_final: got %b expected %b", st_b, 5'b00100);
    end
  endtask

  task automatic test_busy_stale;
    bus_a.ack_async = 1'b0;
    bus_a.tx_data = 8'h11; bus_a.tx_valid = 1'b1;
    tick;
    bus_a.tx_valid = 1'b0;
    bus_a.tx_data = 8'h22; bus_a.tx_valid = 1'b1;
    tick;
    bus_a.tx_valid = 1'b0;
    checks++;
    if (st_a !== 5'b11000 || bus_a.data_out !== 8'h11) begin
      errors++; $display("FAIL busy_ignore_valid: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b11000, 8'h11);
    end
    for (int c = 0; c < 8; c++) begin
      bus_a.ack_async = bus_a.req_out;
      tick;
    end
    checks++;
    if (st_a !== 5'b00100 || bus_a.data_out !== 8'h11) begin
      errors++; $display("FAIL busy_complete: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b00100, 8'h11);
    end
    // Stale ack while idle
    bus_a.ack_async = 1'b1;
    tick;
    checks++;
    if (st_a !== 5'b00100) begin
      errors++; $display("FAIL stale_sync_stage1: got %b expected %b", st_a, 5'b00100);
    end
    tick;
    checks++;
    if (st_a !== 5'b00000) begin
      errors++; $display("FAIL stale_blocks_ready: got %b expected %b", st_a, 5'b00000);
    end
    bus_a.tx_data = 8'h33; bus_a.tx_valid = 1'b1;
    repeat (3) tick;
    checks++;
    if (st_a !== 5'b00000 || bus_a.data_out !== 8'h11) begin
      errors++; $display("FAIL stale_no_accept: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b00000, 8'h11);
    end
    bus_a.tx_valid = 1'b0; bus_a.ack_async = 1'b0;
    tick;
    checks++;
    if (st_a !== 5'b00000) begin
      errors++; $display("FAIL stale_release_sync: got %b expected %b", st_a, 5'b00000);
    end
    tick;
    checks++;
    if (st_a !== 5'b00100) begin
      errors++; $display("FAIL stale_ready_back: got %b expected %b", st_a, 5'b00100);
    end
    // Reset in the middle of REQ
    bus_a.tx_data = 8'h44; bus_a.tx_valid = 1'b1;
    tick;
    bus_a.tx_valid = 1'b0;
    checks++;
    if (st_a !== 5'b11000 || bus_a.data_out !== 8'h44) begin
      errors++; $display("FAIL midreq_accept: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b11000, 8'h44);
    end
    #3 n_rst = 1'b0;
    #1;
    checks++;
    if (st_a !== 5'b00100 || bus_a.data_out !== 8'h00) begin
      errors++; $display("FAIL midreq_reset: got %b/%h expected %b/%h", st_a, bus_a.data_out, 5'b00100, 8'h00);
    end
    #2 n_rst = 1'b1;
    tick;
    checks++;
    if (st_a !== 5'b00100) begin
      errors++; $display("FAIL midreq_restart: got %b expected %b", st_a, 5'b00100);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_back_to_back;
    test_timeout;
    test_late_ack;
    test_busy_stale;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
